// File: rtl/csr_bus_arbiter_pkg.sv
// Shared types and default widths for the CSR bus arbiter
// and the bridge variants built around it.
package csr_bus_pkg;

  localparam int CSR_AW = 14;
  localparam int CSR_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_RDWAIT = 2'b10
  } state_t;

  typedef struct packed {
    logic       we;
    logic [CSR_AW-1:0] a;
    logic [CSR_DW-1:0] dw;
  } csr_cmd_t;

endpackage

// File: rtl/csr_bus_arbiter_if.sv
// Bundle of both requester ports and the CSR slave bus.
// slave = arbiter view, master = requesters + register file.
interface csr_bus_arbiter_if #(
  parameter int AW = csr_bus_pkg::CSR_AW,
  parameter int DW = csr_bus_pkg::CSR_DW
) ();

  logic          M0_REQ;
  logic          M0_WE;
  logic [AW-1:0] M0_A;
  logic [DW-1:0] M0_DW;
  logic          M0_ACK;
  logic [DW-1:0] M0_DR;

  logic          M1_REQ;
  logic          M1_WE;
  logic [AW-1:0] M1_A;
  logic [DW-1:0] M1_DW;
  logic          M1_ACK;
  logic [DW-1:0] M1_DR;

  logic [AW-1:0] CSR_A;
  logic          CSR_WE;
  logic [DW-1:0] CSR_DW;
  logic [DW-1:0] CSR_DR;

  modport slave (
    input  M0_REQ,
    input  M0_WE,
    input  M0_A,
    input  M0_DW,
    output M0_ACK,
    output M0_DR,
    input  M1_REQ,
    input  M1_WE,
    input  M1_A,
    input  M1_DW,
    output M1_ACK,
    output M1_DR,
    output CSR_A,
    output CSR_WE,
    output CSR_DW,
    input  CSR_DR
  );

  modport master (
    output M0_REQ,
    output M0_WE,
    output M0_A,
    output M0_DW,
    input  M0_ACK,
    input  M0_DR,
    output M1_REQ,
    output M1_WE,
    output M1_A,
    output M1_DW,
    input  M1_ACK,
    input  M1_DR,
    input  CSR_A,
    input  CSR_WE,
    input  CSR_DW,
    output CSR_DR
  );

endinterface

// File: rtl/csr_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: prio breaks ties,
// a lone eligible port always wins.
module csr_rr_pick (
  input  logic [1:0] eligible,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Tie goes to prio, otherwise the single eligible port.
  always_comb begin
    gnt_valid = |eligible;
    gnt_idx   = 1'b0;
    unique case (1'b1)
      (eligible == 2'b11): gnt_idx = prio;
      (eligible == 2'b10): gnt_idx = 1'b1;
      default:             gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_bus_arbiter.sv
// Round-robin sharer of one CSR bus between two requesters.
// Writes take one strobe cycle, reads wait one cycle for data.
module csr_bus_arbiter
  import csr_bus_pkg::*;
#(
  parameter int AW = CSR_AW,
  parameter int DW = CSR_DW
) (
  input  logic               PCLK,
  input  logic               PRESERN,
  csr_bus_arbiter_if.slave   bus,
  output logic               BUSY,
  output logic               OWNER
);

  state_t        state;
  logic          prio;
  logic [1:0]    elig;
  logic          gnt_valid;
  logic          gnt_idx;
  logic          win_we;
  logic [AW-1:0] win_a;
  logic [DW-1:0] win_dw;

  // A port is masked while its own ACK is high so a
  // held REQ is not serviced twice.
  assign elig = {bus.M1_REQ & ~bus.M1_ACK,
                 bus.M0_REQ & ~bus.M0_ACK};

  csr_rr_pick u_pick (
    .eligible  (elig),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Command of the port about to be granted.
  always_comb begin
    win_we = bus.M0_WE;
    win_a  = bus.M0_A;
    win_dw = bus.M0_DW;
    if (gnt_idx) begin
      win_we = bus.M1_WE;
      win_a  = bus.M1_A;
      win_dw = bus.M1_DW;
    end
  end

  // Access sequencer; every output is a register here.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      OWNER      <= 1'b0;
      BUSY       <= 1'b0;
      bus.CSR_A  <= '0;
      bus.CSR_WE <= 1'b0;
      bus.CSR_DW <= '0;
      bus.M0_ACK <= 1'b0;
      bus.M1_ACK <= 1'b0;
      bus.M0_DR  <= '0;
      bus.M1_DR  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.M0_ACK <= 1'b0;
          bus.M1_ACK <= 1'b0;
          if (gnt_valid) begin
            OWNER      <= gnt_idx;
            bus.CSR_A  <= win_a;
            bus.CSR_WE <= win_we;
            bus.CSR_DW <= win_we ? win_dw : '0;
            BUSY       <= 1'b1;
            state      <= ST_ISSUE;
          end else begin
            bus.CSR_A  <= '0;
            bus.CSR_WE <= 1'b0;
            bus.CSR_DW <= '0;
            BUSY       <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (bus.CSR_WE) begin
            bus.CSR_WE <= 1'b0;
            bus.CSR_DW <= '0;
            bus.CSR_A  <= '0;
            if (OWNER) bus.M1_ACK <= 1'b1;
            else       bus.M0_ACK <= 1'b1;
            prio  <= ~OWNER;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          if (OWNER) begin
            bus.M1_DR  <= bus.CSR_DR;
            bus.M1_ACK <= 1'b1;
          end else begin
            bus.M0_DR  <= bus.CSR_DR;
            bus.M0_ACK <= 1'b1;
          end
          bus.CSR_A <= '0;
          prio      <= ~OWNER;
          BUSY      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          prio       <= 1'b0;
          OWNER      <= 1'b0;
          BUSY       <= 1'b0;
          bus.CSR_A  <= '0;
          bus.CSR_WE <= 1'b0;
          bus.CSR_DW <= '0;
          bus.M0_ACK <= 1'b0;
          bus.M1_ACK <= 1'b0;
          bus.M0_DR  <= '0;
          bus.M1_DR  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_bus_arbiter.md
Name: csr_bus_arbiter

Overview:
- Shares one CSR slave bus between two requesters.
  - Port 0 is normally the APB-side bridge.
  - Port 1 is normally an on-chip engine, e.g. a DMX frame/DMA sequencer.
- Grants the bus round-robin and sequences each access: a single-cycle write strobe, or a two-cycle read, with read data valid one cycle after the address.
- Returns a one-cycle ACK with read data to the winning requester.
- Sits between the requesters and the existing CSR register file. The CSR side is the only driver of CSR_A/CSR_WE/CSR_DW.

Parameters:
- AW, 14, CSR address width.
- DW, 32, CSR data width.

Ports:
- PCLK  in  1  clock.
- PRESERN  in  1  asynchronous active-low reset.
- M0_REQ  in  1  port 0 request; held high until M0_ACK.
- M0_WE  in  1  port 0 write (1) / read (0); stable while M0_REQ.
- M0_A  in  AW  port 0 address; stable while M0_REQ.
- M0_DW  in  DW  port 0 write data; stable while M0_REQ.
- M0_ACK  out  1  port 0 completion, one-cycle registered pulse.
- M0_DR  out  DW  port 0 read data, valid when M0_ACK and !M0_WE.
- M1_REQ, M1_WE, M1_A, M1_DW, M1_ACK, M1_DR: as port 0, for port 1.
- CSR_A  out  AW  CSR address.
- CSR_WE  out  1  CSR write strobe.
- CSR_DW  out  DW  CSR write data.
- CSR_DR  in  DW  CSR read data; valid the cycle after CSR_A is presented.
- BUSY  out  1  high in every state except IDLE.
- OWNER  out  1  index of the current/last granted port.

Behaviour:
- Single clock PCLK. Asynchronous active-low reset PRESERN.
- Reset values:
  - CSR_A=0, CSR_WE=0, CSR_DW=0.
  - M0_ACK=M1_ACK=0, M0_DR=M1_DR=0.
  - BUSY=0, OWNER=0, priority pointer PRIO=0, state=IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, RDWAIT. Undefined encodings are treated as reset values and go to IDLE.
- IDLE:
  - Eligible requests: Mn_REQ & !Mn_ACK. A port is masked in the cycle its own ACK is high, so a held REQ is never serviced twice.
  - Winner selection:
    - If both ports are eligible, the winner is PRIO.
    - If only one is eligible, that port wins.
  - On a winner:
    - OWNER<=winner.
    - CSR_A<=Mwin_A and CSR_WE<=Mwin_WE.
    - CSR_DW<=Mwin_DW if writing, else 0.
    - Go to ISSUE.
  - If no port is eligible: CSR_* held at 0.
- ISSUE (the CSR access cycle; CSR_WE high here for writes):
  - Write:
    - CSR_WE<=0, CSR_DW<=0, CSR_A<=0.
    - Mowner_ACK<=1.
    - PRIO<=!OWNER.
    - Go to IDLE.
  - Read:
    - CSR_A held and CSR_WE stays 0.
    - Go to RDWAIT.
- RDWAIT:
  - Mowner_DR<=CSR_DR and Mowner_ACK<=1.
  - CSR_A<=0.
  - PRIO<=!OWNER.
  - Go to IDLE.
- ACK is high for exactly one cycle (the cycle after leaving ISSUE/RDWAIT). The non-owner's ACK and DR are never disturbed.
- Latency from the IDLE edge sampling REQ to the ACK-high cycle:
  - write: 2 cycles.
  - read: 3 cycles.
- Back-to-back throughput:
  - writes: one per 2 cycles.
  - reads: one per 3 cycles.
- Fairness:
  - Under continuous contention, grants strictly alternate 0,1,0,1.
  - A lone requester is granted every opportunity regardless of PRIO.
- Requester drops REQ after ACK:
  - If REQ is still high in the cycle after ACK, a new transaction starts.
  - The arbiter never aborts an accepted transaction.
- A change in REQ/A/WE/DW while the port is owned and busy is ignored; the values latched in IDLE are used.
- Reset mid-transaction: all outputs return to reset values immediately, no ACK is issued, and the requester must re-request.
- Address/data widths:
  - Inputs are used as-is at AW/DW.
  - No truncation or sign extension inside the block.

Decomposition:
- Shared package csr_bus_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_ISSUE=2'b01, ST_RDWAIT=2'b10;
  - default CSR_AW=14 and CSR_DW=32 constants, reused by the bridge variants.
- One sub-module is natural: csr_rr_pick.
  - Purely combinational 2-way round-robin picker.
  - Inputs: eligible[1:0], prio.
  - Outputs: gnt_valid, gnt_idx.
- The FSM and datapath stay in csr_bus_arbiter.

Test Plan:
- Port 0 single write, M0_A=0x0010, M0_DW=0xDEADBEEF:
  - CSR_WE high for exactly one cycle with CSR_A=0x0010 and CSR_DW=0xDEADBEEF.
  - M0_ACK pulses 2 cycles after REQ is sampled.
  - M1_ACK stays 0.
- Port 1 read, M1_A=0x0024, slave returns 0x12345678 one cycle after address:
  - M1_ACK pulses 3 cycles after sampling with M1_DR=0x12345678.
  - CSR_WE is never high.
  - M0_DR is unchanged.
- Both ports requesting writes continuously from reset (PRIO=0):
  - Grant order is 0,1,0,1 and OWNER toggles.
  - Each ACK is one cycle wide and there are no duplicate transactions.
- Port 0 holds REQ high for one cycle after ACK, port 1 idle:
  - Exactly one extra (second) port 0 transaction starts.
  - No transaction is started in the ACK cycle itself.
- PRESERN asserted during RDWAIT of a port 0 read:
  - All outputs go to 0 asynchronously and state returns to IDLE.
  - No M0_ACK is issued.
  - After release, a fresh port 0 read completes normally.
- M0_A changed from 0x0004 to 0x0008 during ISSUE of a port 0 read:
  - CSR_A stays 0x0004.
  - M0_DR reflects the read of address 0x0004.
